// File: rtl/pdm_pkg.sv
// Shared types and helpers for the PDM sample scheduler.
// Duty words are signed 16-bit, zero is midscale.
package pdm_pkg;

    localparam int DUTY_W = 16;
    localparam logic signed [DUTY_W-1:0] DUTY_SILENT = 16'sh0000;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        RAMP,
        MUTED
    } sched_state_t;

    // 17-bit compare keeps -32768 from wrapping when stepped toward zero
    function automatic logic signed [DUTY_W-1:0] ramp_to_zero(
        input logic signed [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0]        step
    );
        logic signed [DUTY_W:0] dx;
        logic signed [DUTY_W:0] sx;
        logic signed [DUTY_W:0] nx;
        logic signed [DUTY_W:0] res;
        dx  = {d[DUTY_W-1], d};
        sx  = {1'b0, step};
        nx  = -sx;
        res = '0;
        if (dx > sx) begin
            res = dx - sx;
        end else if (dx < nx) begin
            res = dx + sx;
        end
        return res[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Stereo pair FIFO: registered pointers and occupancy count.
// Read data is presented combinationally from the head entry.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pdm_sample_sched.sv
// Sample-rate scheduler: buffers stereo pairs, releases one per
// sample period to the PDM duty registers, ramps to silence on mute.
module pdm_sample_sched
    import pdm_pkg::*;
#(
    parameter int DEPTH                = 4,
    parameter int SAMPLE_DIV           = 1024,
    parameter int PRIME_LVL            = 2,
    parameter logic [15:0] RAMP_STEP   = 16'h0100,
    localparam int FW                  = $clog2(DEPTH + 1),
    localparam int CNT_W               = $clog2(SAMPLE_DIV)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               smpl_vld,
    output logic               smpl_rdy,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    input  logic               mute,
    output logic signed [15:0] lft_duty,
    output logic signed [15:0] rght_duty,
    output logic               duty_upd,
    output logic               underrun,
    output logic [FW-1:0]      fill
);

    sched_state_t     state;
    sched_state_t     state_nx;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             load;
    logic             ramp;
    logic             ur_nx;
    logic [31:0]      rd_data;

    assign tick     = (cnt == CNT_W'(SAMPLE_DIV - 1));
    assign smpl_rdy = !full;
    assign push     = smpl_vld && smpl_rdy;

    sample_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({lft_smpl, rght_smpl}),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (fill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        ramp     = 1'b0;
        ur_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (mute) begin
                    state_nx = RAMP;
                end else if (fill >= FW'(PRIME_LVL)) begin
                    state_nx = PLAY;
                end
            end
            PLAY: begin
                if (mute) begin
                    state_nx = RAMP;
                end else if (tick && !empty) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end else if (tick) begin
                    ur_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            RAMP: begin
                // buffered pairs keep draining so the queue is stale-free
                ramp = tick;
                pop  = tick && !empty;
                if (lft_duty == DUTY_SILENT && rght_duty == DUTY_SILENT) begin
                    state_nx = MUTED;
                end
            end
            MUTED: begin
                pop = tick && !empty;
                if (!mute) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lft_duty  <= DUTY_SILENT;
            rght_duty <= DUTY_SILENT;
            duty_upd  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            duty_upd <= load || ramp;
            underrun <= ur_nx;
            if (load) begin
                lft_duty  <= rd_data[31:16];
                rght_duty <= rd_data[15:0];
            end else if (ramp) begin
                lft_duty  <= ramp_to_zero(lft_duty, RAMP_STEP);
                rght_duty <= ramp_to_zero(rght_duty, RAMP_STEP);
            end
        end
    end

endmodule

// File: tb/tb_pdm_sample_sched.sv
// Randomised bench for pdm_sample_sched with a queue-based model
// plus directed scenarios pinned by literal duty values.
module tb_pdm_sample_sched;

    localparam int DIV   = 8;
    localparam int DEP   = 4;
    localparam int PRIME = 2;
    localparam int STEP  = 16'h4000;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_RAMP  = 2;
    localparam int M_MUTED = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        smpl_vld = 1'b0;
    logic        smpl_rdy;
    logic [15:0] lft_smpl = '0;
    logic [15:0] rght_smpl = '0;
    logic        mute = 1'b0;
    logic [15:0] lft_duty;
    logic [15:0] rght_duty;
    logic        duty_upd;
    logic        underrun;
    logic [2:0]  fill;

    int n_chk = 0;
    int n_fail = 0;
    bit run_chk = 0;

    pdm_sample_sched #(
        .DEPTH      (DEP),
        .SAMPLE_DIV (DIV),
        .PRIME_LVL  (PRIME),
        .RAMP_STEP  (16'h4000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .smpl_vld  (smpl_vld),
        .smpl_rdy  (smpl_rdy),
        .lft_smpl  (lft_smpl),
        .rght_smpl (rght_smpl),
        .mute      (mute),
        .lft_duty  (lft_duty),
        .rght_duty (rght_duty),
        .duty_upd  (duty_upd),
        .underrun  (underrun),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q_l[$];
    int q_r[$];
    int m_cnt = 0;
    int m_st = M_IDLE;
    int m_dl = 0;
    int m_dr = 0;
    bit m_upd = 0;
    bit m_ur = 0;

    function automatic int toward_zero(input int d);
        if (d > STEP) return d - STEP;
        if (d < -STEP) return d + STEP;
        return 0;
    endfunction

    task automatic model_reset();
        q_l.delete();
        q_r.delete();
        m_cnt = 0;
        m_st = M_IDLE;
        m_dl = 0;
        m_dr = 0;
        m_upd = 0;
        m_ur = 0;
    endtask

    task automatic model_step();
        bit tk;
        bit acc;
        int sz;
        int ns;
        int pl;
        int pr;
        tk = (m_cnt == DIV - 1);
        m_cnt = tk ? 0 : m_cnt + 1;
        sz = q_l.size();
        acc = smpl_vld && (sz < DEP);
        ns = m_st;
        m_upd = 0;
        m_ur = 0;
        case (m_st)
            M_IDLE: begin
                if (mute) ns = M_RAMP;
                else if (sz >= PRIME) ns = M_PLAY;
            end
            M_PLAY: begin
                if (mute) begin
                    ns = M_RAMP;
                end else if (tk && sz > 0) begin
                    pl = q_l.pop_front();
                    pr = q_r.pop_front();
                    m_dl = pl;
                    m_dr = pr;
                    m_upd = 1;
                end else if (tk) begin
                    m_ur = 1;
                    ns = M_IDLE;
                end
            end
            M_RAMP: begin
                if (m_dl == 0 && m_dr == 0) ns = M_MUTED;
                if (tk) begin
                    m_dl = toward_zero(m_dl);
                    m_dr = toward_zero(m_dr);
                    m_upd = 1;
                    if (sz > 0) begin
                        pl = q_l.pop_front();
                        pr = q_r.pop_front();
                    end
                end
            end
            default: begin
                if (tk && sz > 0) begin
                    pl = q_l.pop_front();
                    pr = q_r.pop_front();
                end
                if (!mute) ns = M_IDLE;
            end
        endcase
        if (acc) begin
            q_l.push_back(int'($signed(lft_smpl)));
            q_r.push_back(int'($signed(rght_smpl)));
        end
        m_st = ns;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            check("lft_duty", lft_duty, m_dl & 32'hFFFF);
            check("rght_duty", rght_duty, m_dr & 32'hFFFF);
            check("duty_upd", duty_upd, m_upd);
            check("underrun", underrun, m_ur);
            check("fill", fill, q_l.size());
            check("smpl_rdy", smpl_rdy, q_l.size() < DEP);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        smpl_vld = 1'b0;
        mute = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic push1(input logic [15:0] l, input logic [15:0] r);
        @(posedge clk);
        #1 smpl_vld = 1'b1;
        lft_smpl = l;
        rght_smpl = r;
    endtask

    task automatic idle_in();
        @(posedge clk);
        #1 smpl_vld = 1'b0;
    endtask

    task automatic wait_upd(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!duty_upd && k < 40);
        check(nm, duty_upd, 1);
    endtask

    task automatic wait_ur(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!underrun && k < 40);
        check(nm, underrun, 1);
    endtask

    initial begin
        int ups;
        #1 rst_n = 1'b0;
        run_chk = 1;
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_fill", fill, 0);
        check("reset_rdy", smpl_rdy, 1);

        // two pairs prime PLAY, released in order, then underrun
        push1(16'h1000, 16'hF000);
        push1(16'h2000, 16'hE000);
        idle_in();
        wait_upd("first_upd");
        check("first_l", lft_duty, 16'h1000);
        check("first_r", rght_duty, 16'hF000);
        wait_upd("second_upd");
        check("second_l", lft_duty, 16'h2000);
        check("second_r", rght_duty, 16'hE000);
        wait_ur("underrun_seen");
        check("ur_hold_l", lft_duty, 16'h2000);
        check("ur_hold_r", rght_duty, 16'hE000);

        // five back-to-back pushes: fourth fills, fifth refused
        do_reset();
        push1(16'h0011, 16'h0022);
        push1(16'h0033, 16'h0044);
        push1(16'h0055, 16'h0066);
        push1(16'h0077, 16'h0088);
        push1(16'h0099, 16'h00AA);
        #1 check("full_rdy", smpl_rdy, 0);
        idle_in();
        #1 check("full_fill", fill, 4);
        wait_upd("drain_upd");
        check("drain_l", lft_duty, 16'h0011);
        repeat (40) @(posedge clk);

        // ramp from extremes without overflow
        do_reset();
        push1(16'h7FFF, 16'h8000);
        push1(16'h0001, 16'h0001);
        idle_in();
        wait_upd("ext_upd");
        check("ext_l", lft_duty, 16'h7FFF);
        check("ext_r", rght_duty, 16'h8000);
        @(posedge clk);
        #1 mute = 1'b1;
        wait_upd("ramp1_upd");
        check("ramp1_l", lft_duty, 16'h3FFF);
        check("ramp1_r", rght_duty, 16'hC000);
        wait_upd("ramp2_upd");
        check("ramp2_l", lft_duty, 16'h0000);
        check("ramp2_r", rght_duty, 16'h0000);
        repeat (12) @(posedge clk);
        #1 check("muted_fill", fill, 0);
        mute = 1'b0;
        repeat (4) @(posedge clk);

        // reset in the middle of a ramp
        push1(16'h7FFF, 16'h8000);
        push1(16'h0001, 16'h0001);
        idle_in();
        wait_upd("pre_rst_upd");
        @(posedge clk);
        #1 mute = 1'b1;
        wait_upd("mid_ramp_upd");
        @(posedge clk);
        #1 rst_n = 1'b0;
        mute = 1'b0;
        #1;
        check("rst_l", lft_duty, 0);
        check("rst_r", rght_duty, 0);
        check("rst_fill", fill, 0);
        check("rst_upd", duty_upd, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ups = 0;
        repeat (12) begin
            @(negedge clk);
            if (duty_upd) ups++;
        end
        check("post_rst_no_upd", ups, 0);

        // randomised traffic and mute toggling
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            smpl_vld = ($urandom_range(2, 0) != 0);
            lft_smpl = 16'($urandom);
            rght_smpl = 16'($urandom);
            if ($urandom_range(63, 0) == 0) mute = !mute;
            if (i == 700) begin
                lft_smpl = 16'h8000;
                rght_smpl = 16'h7FFF;
            end
        end
        idle_in();
        repeat (4) @(posedge clk);
        @(negedge clk);
        run_chk = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
